// File: rtl/fc28_scan_pkg.sv
// Shared constants for the FC-28 scan sequencer: Avalon register addresses,
// CONTROL bit positions and FSM state encoding (also reported in INFO[6:4]).
package fc28_scan_pkg;

  // Register map
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_SETTLE  = 3'd2;
  localparam logic [2:0] ADDR_PERIOD  = 3'd3;
  localparam logic [2:0] ADDR_CHANGED = 3'd4;
  localparam logic [2:0] ADDR_INFO    = 3'd5;

  // CONTROL bits
  localparam int CTRL_EN    = 0;
  localparam int CTRL_START = 1;
  localparam int CTRL_IE    = 2;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_POWER  = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_NEXT   = 3'd4;
  localparam logic [2:0] ST_WAIT   = 3'd5;

  // True for the states in which the selected probe is powered.
  function automatic logic is_powered(input logic [2:0] st);
    return (st == ST_POWER) || (st == ST_SAMPLE) || (st == ST_COMMIT);
  endfunction

endpackage

// File: rtl/fc28_majority_sampler.sv
// Shared sampling datapath: 2-FF synchronizers on every sensor line, a mux
// selecting the sensor under measurement, and a ones counter whose majority
// decision is presented on level.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   sensor_in     raw asynchronous sensor DO lines
//   idx           sensor currently being measured
//   clear         zero the ones counter (held while the probe settles)
//   enable        add the selected synchronized bit this cycle
//   level         1 when more than NSAMP/2 ones were counted (ties give 0)
module fc28_majority_sampler
  import fc28_scan_pkg::*;
#(
  parameter int N_SENSORS = 4,
  parameter int NSAMP     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_SENSORS-1:0] sensor_in,
  input  logic [2:0]           idx,
  input  logic                 clear,
  input  logic                 enable,
  output logic                 level
);

  localparam int ONES_W = $clog2(NSAMP) + 1;

  logic [N_SENSORS-1:0] meta_r;
  logic [N_SENSORS-1:0] sync_r;
  logic [7:0]           sync_ext_s;
  logic                 sel_s;
  logic [ONES_W-1:0]    ones_r;

  // Two-stage synchronizer for every sensor line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= sensor_in;
      sync_r <= meta_r;
    end
  end

  // Zero-extend to 8 lanes so any 3-bit idx is a legal select
  assign sync_ext_s = 8'(sync_r);
  assign sel_s      = sync_ext_s[idx];

  // Ones counter for the sample window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ones_r <= '0;
    end else if (clear) begin
      ones_r <= '0;
    end else if (enable) begin
      ones_r <= ones_r + ONES_W'(sel_s);
    end else begin
      ones_r <= ones_r;
    end
  end

  assign level = (ones_r > ONES_W'(NSAMP / 2));

endmodule

// File: rtl/fc28_scan_sequencer.sv
// Avalon-MM controlled scan sequencer for FC-28 soil-moisture probes. Powers
// one probe at a time, lets it settle, majority-votes NSAMP samples, records
// the level in STATUS, flags changes in CHANGED and raises irq when enabled.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   address, write, writedata        Avalon-MM slave write side
//   readdata                         registered read data (address of prior cycle)
//   sensor_in                        raw asynchronous sensor DO lines
//   sensor_pwr                       one-hot registered probe power enables
//   busy                             FSM is not IDLE
//   irq                              IE & |CHANGED
module fc28_scan_sequencer
  import fc28_scan_pkg::*;
#(
  parameter int N_SENSORS = 4,
  parameter int NSAMP     = 8,
  parameter int CNT_W     = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           address,
  input  logic                 write,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic [N_SENSORS-1:0] sensor_in,
  output logic [N_SENSORS-1:0] sensor_pwr,
  output logic                 busy,
  output logic                 irq
);

  localparam int                   IDX_W    = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
  localparam logic [2:0]           IDX_LAST = 3'(N_SENSORS - 1);
  localparam logic [N_SENSORS-1:0] PWR_ONE  = {{(N_SENSORS-1){1'b0}}, 1'b1};

  logic [2:0]           state_r, state_nx_s;
  logic [2:0]           idx_r, idx_nx_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nx_s;
  logic                 one_shot_r, one_shot_nx_s;
  logic                 start_clr_s, start_nx_s;
  logic                 en_r, start_r, ie_r;
  logic [CNT_W-1:0]     settle_r, period_r, settle_load_s;
  logic [N_SENSORS-1:0] status_r, status_nx_s;
  logic [N_SENSORS-1:0] changed_r, set_s, w1c_s;
  logic [N_SENSORS-1:0] pwr_nx_s;
  logic [IDX_W-1:0]     idx_sel_s;
  logic [31:0]          rd_s;
  logic                 wr_ctrl_s, level_s;
  logic                 unused_wdata_s;

  assign unused_wdata_s = ^writedata;
  assign wr_ctrl_s      = write && (address == ADDR_CONTROL);
  assign w1c_s          = (write && (address == ADDR_CHANGED)) ? writedata[N_SENSORS-1:0] : '0;
  assign idx_sel_s      = idx_r[IDX_W-1:0];
  // SETTLE=0 still gives one POWER cycle
  assign settle_load_s  = (settle_r == '0) ? CNT_W'(0) : settle_r - CNT_W'(1);
  assign busy           = (state_r != ST_IDLE);
  assign irq            = ie_r & (|changed_r);

  fc28_majority_sampler #(
    .N_SENSORS(N_SENSORS),
    .NSAMP    (NSAMP)
  ) u_sampler (
    .clk      (clk),
    .reset_n  (reset_n),
    .sensor_in(sensor_in),
    .idx      (idx_r),
    .clear    (state_r == ST_POWER),
    .enable   (state_r == ST_SAMPLE),
    .level    (level_s)
  );

  // Next-state logic. one_shot remembers a START-initiated round so that
  // clearing EN mid-round still lets that round finish.
  always_comb begin
    state_nx_s    = state_r;
    idx_nx_s      = idx_r;
    cnt_nx_s      = cnt_r;
    one_shot_nx_s = one_shot_r;
    start_clr_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en_r || start_r) begin
          state_nx_s    = ST_POWER;
          idx_nx_s      = 3'd0;
          cnt_nx_s      = settle_load_s;
          one_shot_nx_s = start_r;
          start_clr_s   = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_POWER: begin
        if (cnt_r == '0) begin
          state_nx_s = ST_SAMPLE;
          cnt_nx_s   = CNT_W'(NSAMP - 1);
        end else begin
          cnt_nx_s = cnt_r - CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (cnt_r == '0) begin
          state_nx_s = ST_COMMIT;
        end else begin
          cnt_nx_s = cnt_r - CNT_W'(1);
        end
      end
      ST_COMMIT: begin
        state_nx_s = ST_NEXT;
      end
      ST_NEXT: begin
        if (!en_r && !one_shot_r) begin
          state_nx_s    = ST_IDLE;
          idx_nx_s      = 3'd0;
          one_shot_nx_s = 1'b0;
        end else if (idx_r == IDX_LAST) begin
          state_nx_s = ST_WAIT;
          idx_nx_s   = 3'd0;
          cnt_nx_s   = period_r;
        end else begin
          state_nx_s = ST_POWER;
          idx_nx_s   = idx_r + 3'd1;
          cnt_nx_s   = settle_load_s;
        end
      end
      ST_WAIT: begin
        // WAIT lasts PERIOD+1 cycles
        if (cnt_r != '0) begin
          cnt_nx_s = cnt_r - CNT_W'(1);
        end else if (en_r) begin
          state_nx_s    = ST_POWER;
          cnt_nx_s      = settle_load_s;
          one_shot_nx_s = 1'b0;
        end else begin
          state_nx_s    = ST_IDLE;
          one_shot_nx_s = 1'b0;
        end
      end
      default: begin
        state_nx_s    = ST_IDLE;
        idx_nx_s      = 3'd0;
        cnt_nx_s      = '0;
        one_shot_nx_s = 1'b0;
      end
    endcase
  end

  // Power enable follows the next state so it is exact on every state boundary
  always_comb begin
    pwr_nx_s = '0;
    if (is_powered(state_nx_s)) begin
      pwr_nx_s = PWR_ONE << idx_nx_s;
    end else begin
      pwr_nx_s = '0;
    end
  end

  // START self-clears on IDLE exit and is only accepted while IDLE
  always_comb begin
    start_nx_s = start_r;
    if (start_clr_s) begin
      start_nx_s = 1'b0;
    end else if (wr_ctrl_s && (state_r == ST_IDLE)) begin
      start_nx_s = writedata[CTRL_START];
    end else begin
      start_nx_s = start_r;
    end
  end

  // Commit of the majority level and the matching change flag
  always_comb begin
    status_nx_s = status_r;
    set_s       = '0;
    if (state_r == ST_COMMIT) begin
      status_nx_s[idx_sel_s] = level_s;
      set_s[idx_sel_s]       = level_s ^ status_r[idx_sel_s];
    end else begin
      status_nx_s = status_r;
    end
  end

  // Read mux; unmapped addresses and unused bits read as zero
  always_comb begin
    rd_s = 32'd0;
    case (address)
      ADDR_STATUS:  rd_s = 32'(status_r);
      ADDR_CONTROL: begin
        rd_s[CTRL_EN]    = en_r;
        rd_s[CTRL_START] = start_r;
        rd_s[CTRL_IE]    = ie_r;
      end
      ADDR_SETTLE:  rd_s = 32'(settle_r);
      ADDR_PERIOD:  rd_s = 32'(period_r);
      ADDR_CHANGED: rd_s = 32'(changed_r);
      ADDR_INFO:    rd_s = {25'd0, state_r, 1'b0, idx_r};
      default:      rd_s = 32'd0;
    endcase
  end

  // FSM, counter and probe power registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= 3'd0;
      cnt_r      <= '0;
      one_shot_r <= 1'b0;
      sensor_pwr <= '0;
    end else begin
      state_r    <= state_nx_s;
      idx_r      <= idx_nx_s;
      cnt_r      <= cnt_nx_s;
      one_shot_r <= one_shot_nx_s;
      sensor_pwr <= pwr_nx_s;
    end
  end

  // Register file; a hardware set of CHANGED wins over a same-cycle W1C
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_r      <= 1'b0;
      start_r   <= 1'b0;
      ie_r      <= 1'b0;
      settle_r  <= '0;
      period_r  <= '0;
      status_r  <= '0;
      changed_r <= '0;
      readdata  <= 32'd0;
    end else begin
      en_r      <= wr_ctrl_s ? writedata[CTRL_EN] : en_r;
      ie_r      <= wr_ctrl_s ? writedata[CTRL_IE] : ie_r;
      start_r   <= start_nx_s;
      settle_r  <= (write && (address == ADDR_SETTLE)) ? writedata[CNT_W-1:0] : settle_r;
      period_r  <= (write && (address == ADDR_PERIOD)) ? writedata[CNT_W-1:0] : period_r;
      status_r  <= status_nx_s;
      changed_r <= (changed_r & ~w1c_s) | set_s;
      readdata  <= rd_s;
    end
  end

endmodule

// File: tb/tb_fc28_scan_sequencer.sv
// Directed self-checking bench for fc28_scan_sequencer (N_SENSORS=4, NSAMP=8).
// All stimulus is applied and all outputs sampled on the falling clock edge.
module tb_fc28_scan_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  sensor_in;
  logic [3:0]  sensor_pwr;
  logic        busy;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fc28_scan_sequencer #(.N_SENSORS(4), .NSAMP(8), .CNT_W(24)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .sensor_in (sensor_in),
    .sensor_pwr(sensor_pwr),
    .busy      (busy),
    .irq       (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0; writedata = 32'd0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    address = a;
    @(negedge clk);
    chk(tag, readdata, exp);
  endtask

  task automatic wait_pwr(input logic [3:0] v, input int bound, input string tag);
    int n;
    n = 0;
    while (sensor_pwr !== v && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(sensor_pwr), 32'(v));
  endtask

  task automatic measure(input logic [3:0] v, input int len, input string tag);
    int n;
    wait_pwr(v, 500, tag);
    n = 0;
    while (sensor_pwr === v && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_len"}, 32'(n), 32'(len));
    chk({tag, "_off"}, 32'(sensor_pwr), 32'd0);
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_round_end(input string tag);
    int n;
    wait_pwr(4'b1000, 400, tag);
    n = 0;
    while (sensor_pwr === 4'b1000 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_off"}, 32'(sensor_pwr), 32'd0);
  endtask

  // Single START round with sensor 0 high for sample inputs lo..hi (edges after POWER entry)
  task automatic majority_round(input int lo, input int hi);
    sensor_in = 4'b0000;
    wr(3'd1, 32'h6);
    wait_pwr(4'b0001, 50, "maj_pwr");
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      #1;
      sensor_in[0] = (k >= lo) && (k <= hi);
    end
    sensor_in = 4'b0000;
    wait_idle(200, "maj_idle");
  endtask

  // Global time limit
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic any_s;
    reset_n   = 1'b0;
    address   = 3'd0;
    write     = 1'b0;
    writedata = 32'd0;
    sensor_in = 4'b0000;
    repeat (3) @(negedge clk);
    chk("in_reset_pwr", 32'(sensor_pwr), 32'd0);
    chk("in_reset_rd", readdata, 32'd0);
    reset_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_outs", {26'd0, sensor_pwr, busy, irq}, 32'd0);
      chk("idle_rd", readdata, 32'd0);
    end

    // Single round, SETTLE=10, sensors 0 and 2 high
    sensor_in = 4'b0101;
    wr(3'd2, 32'd10);
    wr(3'd1, 32'h2);
    for (int s = 0; s < 4; s++) measure(4'(1 << s), 19, "single_pwr");
    wait_idle(50, "single_idle");
    rd(3'd0, 32'h5, "single_status");
    rd(3'd4, 32'h5, "single_changed");
    chk("irq_ie0", 32'(irq), 32'd0);
    rd(3'd1, 32'h0, "start_selfclear");
    wr(3'd1, 32'h4);
    chk("irq_ie1", 32'(irq), 32'd1);
    wr(3'd4, 32'hF);
    chk("irq_w1c", 32'(irq), 32'd0);

    // Majority: 5 of 8 ones -> 1, 4 of 8 -> 0
    majority_round(10, 14);
    rd(3'd0, 32'h1, "maj5_status");
    rd(3'd4, 32'h4, "maj5_changed");
    wr(3'd4, 32'hF);
    majority_round(10, 13);
    rd(3'd0, 32'h0, "maj4_status");
    rd(3'd4, 32'h1, "maj4_changed");
    wr(3'd4, 32'hF);

    // Continuous scan with PERIOD=100
    sensor_in = 4'b1011;
    wr(3'd3, 32'd100);
    wr(3'd1, 32'h5);
    for (int s = 0; s < 4; s++) measure(4'(1 << s), 19, "cont_pwr");
    n = 0;
    while (sensor_pwr === 4'b0000 && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("cont_gap", 32'(n), 32'd102);
    chk("cont_restart", 32'(sensor_pwr), 32'h1);
    rd(3'd4, 32'hB, "cont_changed1");
    rd(3'd0, 32'hB, "cont_status1");
    wait_round_end("cont_r2");
    rd(3'd4, 32'hB, "cont_changed2");
    wr(3'd4, 32'hF);
    chk("cont_irq_clr", 32'(irq), 32'd0);
    sensor_in = 4'b1111;
    wait_round_end("cont_r3");
    rd(3'd4, 32'h4, "toggle_changed");
    chk("toggle_irq", 32'(irq), 32'd1);
    wr(3'd4, 32'h4);
    chk("toggle_irq_clr", 32'(irq), 32'd0);

    // Abort: clear EN while sensor 1 samples
    wait_pwr(4'b0010, 400, "abort_pwr");
    sensor_in = 4'b1001;
    rd(3'd5, 32'h11, "info_power1");
    repeat (11) @(negedge clk);
    wr(3'd1, 32'h4);
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_latency", 32'(n <= 11), 32'd1);
    any_s = 1'b0;
    repeat (60) begin
      @(negedge clk);
      any_s = any_s | (|sensor_pwr);
    end
    chk("abort_no_pwr", 32'(any_s), 32'd0);
    rd(3'd0, 32'hD, "abort_status");
    rd(3'd4, 32'h2, "abort_changed");

    // Collision: W1C of CHANGED[0] on the commit cycle; START while busy
    wr(3'd4, 32'hF);
    chk("coll_irq_clr", 32'(irq), 32'd0);
    sensor_in = 4'b0000;
    wr(3'd1, 32'h6);
    wait_pwr(4'b0001, 50, "coll_pwr");
    repeat (18) @(negedge clk);
    wr(3'd4, 32'h1);
    wr(3'd1, 32'h6);
    wait_idle(200, "coll_idle");
    rd(3'd4, 32'hD, "coll_changed");
    rd(3'd0, 32'h0, "coll_status");
    rd(3'd1, 32'h4, "busy_start_ignored");
    any_s = 1'b0;
    repeat (60) begin
      @(negedge clk);
      any_s = any_s | busy;
    end
    chk("no_extra_round", 32'(any_s), 32'd0);

    // SETTLE=0 behaves as 1
    wr(3'd2, 32'd0);
    wr(3'd1, 32'h2);
    measure(4'b0001, 10, "settle0_pwr");
    wait_idle(200, "settle0_idle");

    // Register widths, RO and unmapped addresses
    wr(3'd2, 32'hFFFF_FFFF);
    rd(3'd2, 32'h00FF_FFFF, "settle_width");
    rd(3'd3, 32'd100, "period_rb");
    wr(3'd0, 32'hF);
    rd(3'd0, 32'h0, "status_ro");
    wr(3'd6, 32'hFF);
    rd(3'd6, 32'h0, "addr6");
    rd(3'd7, 32'h0, "addr7");
    rd(3'd5, 32'h0, "info_idle");

    // Asynchronous reset in the middle of a measurement
    wr(3'd1, 32'h5);
    wait_pwr(4'b0001, 20, "rst_pwr");
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_pwr", 32'(sensor_pwr), 32'd0);
    chk("rst_async_flags", {30'd0, busy, irq}, 32'd0);
    chk("rst_async_rd", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(3'd1, 32'h0, "rst_control");
    rd(3'd2, 32'h0, "rst_settle");
    any_s = 1'b0;
    repeat (20) begin
      @(negedge clk);
      any_s = any_s | (|sensor_pwr) | busy;
    end
    chk("rst_stays_idle", 32'(any_s), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
